// File: rtl/interleaver_ctrl.sv
// Frame sequencer for a block interleaver: reset pulse, fill phase, emit phase,
// then a bounded wait for the interleaver's read-complete flag.
module interleaver_ctrl #(
  parameter int unsigned FRAME_BITS = 2880,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned TO_MARGIN  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] n_slots_req,
  input  logic       abort,
  input  logic       il_out_en,
  output logic       start_ack,
  output logic       busy,
  output logic       il_reset,
  output logic [4:0] il_n_slots,
  output logic       il_in_en,
  output logic       bit_valid,
  output logic       frame_done,
  output logic       cfg_err,
  output logic       timeout_err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RST  = 3'd1,
    FILL = 3'd2,
    EMIT = 3'd3,
    WAIT = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [11:0] FRAME_LAST = 12'(FRAME_BITS - 1);
  localparam logic [11:0] RST_LAST   = 12'(RST_CYCLES - 1);
  localparam logic [11:0] TO_LAST    = 12'(TO_MARGIN - 1);

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic        aborting_q, aborting_d;
  logic        start_ack_q, start_ack_d;
  logic        cfg_err_q, cfg_err_d;
  logic        timeout_err_q, timeout_err_d;
  logic        il_reset_q, il_reset_d;
  logic        bit_valid_q, bit_valid_d;
  logic [4:0]  il_n_slots_q, il_n_slots_d;
  logic        req_ok;

  assign req_ok = (n_slots_req == 5'd2) || (n_slots_req == 5'd4) ||
                  (n_slots_req == 5'd8) || (n_slots_req == 5'd16);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    aborting_d    = aborting_q;
    start_ack_d   = 1'b0;
    cfg_err_d     = 1'b0;
    timeout_err_d = timeout_err_q;
    il_n_slots_d  = il_n_slots_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          if (req_ok) begin
            state_d       = RST;
            start_ack_d   = 1'b1;
            il_n_slots_d  = n_slots_req;
            timeout_err_d = 1'b0;
            aborting_d    = 1'b0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RST: begin
        if (cnt_q == RST_LAST) begin
          cnt_d      = '0;
          state_d    = aborting_q ? IDLE : FILL;
          aborting_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      FILL: begin
        if (cnt_q == FRAME_LAST) begin
          cnt_d   = '0;
          state_d = EMIT;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      EMIT: begin
        if (cnt_q == FRAME_LAST) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      WAIT: begin
        if (il_out_en) begin
          cnt_d   = '0;
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          cnt_d         = '0;
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Abort restarts the reset pulse and suppresses completion of the frame.
    if (abort && (state_q != IDLE) && (state_q <= DONE)) begin
      state_d       = RST;
      cnt_d         = '0;
      aborting_d    = 1'b1;
      timeout_err_d = timeout_err_q;
    end

    il_reset_d  = (state_d == RST);
    bit_valid_d = (state_q == EMIT) && !abort;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      aborting_q    <= 1'b0;
      start_ack_q   <= 1'b0;
      cfg_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      il_reset_q    <= 1'b1;
      bit_valid_q   <= 1'b0;
      il_n_slots_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      aborting_q    <= aborting_d;
      start_ack_q   <= start_ack_d;
      cfg_err_q     <= cfg_err_d;
      timeout_err_q <= timeout_err_d;
      il_reset_q    <= il_reset_d;
      bit_valid_q   <= bit_valid_d;
      il_n_slots_q  <= il_n_slots_d;
    end
  end

  assign start_ack   = start_ack_q;
  assign busy        = (state_q != IDLE);
  assign il_reset    = il_reset_q;
  assign il_n_slots  = il_n_slots_q;
  assign il_in_en    = (state_q == FILL) || (state_q == EMIT);
  assign bit_valid   = bit_valid_q;
  assign frame_done  = (state_q == DONE);
  assign cfg_err     = cfg_err_q;
  assign timeout_err = timeout_err_q;
  assign state       = state_q;

endmodule

// File: tb/tb_interleaver_ctrl.sv
// Bench for interleaver_ctrl: each frame is compared cycle by cycle against a
// timeline computed from the phase lengths, plus per-frame event counts.
module tb_interleaver_ctrl;
  localparam int R = 2;
  localparam int F = 2880;
  localparam int M = 16;
  localparam int W = R + 2 * F + 1;  // sample index of the first WAIT cycle

  logic       clk;
  logic       reset;
  logic       start;
  logic [4:0] n_slots_req;
  logic       abort;
  logic       il_out_en;
  logic       start_ack;
  logic       busy;
  logic       il_reset;
  logic [4:0] il_n_slots;
  logic       il_in_en;
  logic       bit_valid;
  logic       frame_done;
  logic       cfg_err;
  logic       timeout_err;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  interleaver_ctrl #(.FRAME_BITS(F), .RST_CYCLES(R), .TO_MARGIN(M)) dut (
    .clk(clk), .reset(reset), .start(start), .n_slots_req(n_slots_req),
    .abort(abort), .il_out_en(il_out_en), .start_ack(start_ack), .busy(busy),
    .il_reset(il_reset), .il_n_slots(il_n_slots), .il_in_en(il_in_en),
    .bit_valid(bit_valid), .frame_done(frame_done), .cfg_err(cfg_err),
    .timeout_err(timeout_err), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] dut_vec();
    return {state, start_ack, busy, il_reset, il_n_slots, il_in_en,
            bit_valid, frame_done, cfg_err, timeout_err};
  endfunction

  // Expected outputs at sample k after start is raised at sample 0.
  // ev_kind: 0 none, 1 abort driven at sample ev_k, 2 reset driven at sample ev_k.
  // d: WAIT cycles before il_out_en pulses (d >= M means it never does).
  function automatic logic [15:0] model(int k, logic [4:0] n, int ev_kind, int ev_k, int d);
    logic [2:0] st;
    logic ack, bsy, ilr, inen, bv, done, tmo;
    logic [4:0] ns;
    st = 3'd0; ack = 0; bsy = 0; ilr = 0; inen = 0; bv = 0; done = 0; tmo = 0; ns = n;
    if (ev_kind == 2 && k > ev_k) begin
      ilr = 1; ns = 5'd0;
    end else if (ev_kind == 1 && k > ev_k) begin
      if (k <= ev_k + R) begin st = 3'd1; bsy = 1; ilr = 1; end
    end else begin
      ack = (k == 1);
      if (k <= R) begin st = 3'd1; ilr = 1; end
      else if (k <= R + F) begin st = 3'd2; inen = 1; end
      else if (k <= R + 2 * F) begin st = 3'd3; inen = 1; end
      else if (d < M && k <= W + d) st = 3'd4;
      else if (d < M && k == W + d + 1) begin st = 3'd5; done = 1; end
      else if (d >= M && k < W + M) st = 3'd4;
      else begin st = 3'd0; tmo = (d >= M); end
      bsy = (st != 3'd0);
      bv = (k >= R + F + 2) && (k <= R + 2 * F + 1);
    end
    return {st, ack, bsy, ilr, ns, inen, bv, done, 1'b0, tmo};
  endfunction

  // Entered and left at a falling edge with the DUT in IDLE (unless reset event).
  task automatic run_frame(input string name, input logic [4:0] n, input int ev_kind,
                           input int ev_k, input int d, input logic keep_start);
    int k_end, bad, fk, n_bv, n_inen, n_ack, n_done;
    logic [15:0] act, exp_v, fa, fe;
    if (ev_kind == 2) k_end = ev_k + 1;
    else if (ev_kind == 1) k_end = ev_k + R + 1;
    else if (d < M) k_end = W + d + 2;
    else k_end = W + M;
    bad = 0; fk = 0; fa = '0; fe = '0; n_bv = 0; n_inen = 0; n_ack = 0; n_done = 0;
    start = 1'b1;
    n_slots_req = n;
    for (int k = 1; k <= k_end; k++) begin
      @(negedge clk);
      act = dut_vec();
      exp_v = model(k, n, ev_kind, ev_k, d);
      if (act !== exp_v) begin
        if (bad == 0) begin fk = k; fa = act; fe = exp_v; end
        bad++;
      end
      n_bv += int'(bit_valid); n_inen += int'(il_in_en);
      n_ack += int'(start_ack); n_done += int'(frame_done);
      if (!keep_start && k == 1) start = 1'b0;
      il_out_en = (d < M) && (k == W + d);
      abort = (ev_kind == 1) && (k == ev_k);
      reset = (ev_kind == 2) && (k == ev_k);
    end
    il_out_en = 1'b0;
    abort = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s trace: %0d bad cycles, first k=%0d actual=%h required=%h",
               name, bad, fk, fa, fe);
    end
    if (ev_kind == 0) begin
      checks++;
      if (n_bv !== F) begin errors++; $display("FAIL %s bit_valid_count: actual=%0d required=%0d", name, n_bv, F); end
      checks++;
      if (n_inen !== 2 * F) begin errors++; $display("FAIL %s il_in_en_count: actual=%0d required=%0d", name, n_inen, 2 * F); end
      checks++;
      if (n_ack !== 1) begin errors++; $display("FAIL %s start_ack_count: actual=%0d required=1", name, n_ack); end
      checks++;
      if (n_done !== int'(d < M)) begin errors++; $display("FAIL %s frame_done_count: actual=%0d required=%0d", name, n_done, int'(d < M)); end
    end
    $display("frame %s: n=%0d ev=%0d@%0d d=%0d bv=%0d in_en=%0d bad=%0d", name, n, ev_kind, ev_k, d, n_bv, n_inen, bad);
  endtask

  task automatic test_reset();
    logic [15:0] rv;
    reset = 1'b1; start = 1'b1; n_slots_req = 5'd2; abort = 1'b1; il_out_en = 1'b0;
    rv = {3'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0};
    repeat (3) @(negedge clk);
    checks++;
    if (dut_vec() !== rv) begin errors++; $display("FAIL reset_values: actual=%h required=%h", dut_vec(), rv); end
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    checks++;
    if (dut_vec() !== 16'h0000) begin errors++; $display("FAIL reset_release: actual=%h required=0000", dut_vec()); end
    $display("reset: done");
  endtask

  task automatic test_cfg_err();
    logic [4:0] bad_n;
    start = 1'b1; n_slots_req = 5'd5;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({state, start_ack, busy, cfg_err} !== 6'b000_0_0_1) begin
        errors++;
        $display("FAIL cfg_err_pulse %0d: actual st=%0d ack=%b busy=%b cfg=%b required st=0 ack=0 busy=0 cfg=1",
                 i, state, start_ack, busy, cfg_err);
      end
      do bad_n = 5'($urandom_range(0, 31));
      while (bad_n == 5'd2 || bad_n == 5'd4 || bad_n == 5'd8 || bad_n == 5'd16);
      n_slots_req = (i == 7) ? n_slots_req : bad_n;
      if (i == 7) start = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_clear: actual=%b required=0", cfg_err); end
    run_frame("cfg_then_16", 5'd16, 0, 0, 4, 1'b0);
  endtask

  task automatic test_timeout();
    run_frame("timeout", 5'd4, 0, 0, 1000, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if ({timeout_err, state} !== 4'b1_000) begin
      errors++;
      $display("FAIL timeout_sticky: actual tmo=%b st=%0d required tmo=1 st=0", timeout_err, state);
    end
  endtask

  task automatic test_abort();
    run_frame("abort_fill1000", 5'd8, 1, R + 1 + 1000, 3, 1'b0);
    run_frame("after_abort", 5'd8, 0, 0, 7, 1'b0);
  endtask

  task automatic test_abort_idle();
    abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({state, busy, il_reset} !== 5'b000_0_0) begin
        errors++;
        $display("FAIL abort_idle %0d: actual st=%0d busy=%b ilr=%b required 0/0/0", i, state, busy, il_reset);
      end
    end
    abort = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_frame("b2b_1", 5'd2, 0, 0, 2, 1'b1);
    run_frame("b2b_2", 5'd4, 0, 0, 5, 1'b1);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: actual busy=%b required=0", busy); end
  endtask

  task automatic test_random();
    int d, evk, last_busy, kind;
    logic [4:0] n;
    for (int i = 0; i < 3; i++) begin
      n = 5'(2 << $urandom_range(0, 3));
      d = $urandom_range(0, 20);
      kind = $urandom_range(0, 1);
      last_busy = (d < M) ? W + d + 1 : W + M - 1;
      evk = $urandom_range(1, last_busy);
      run_frame($sformatf("rand%0d", i), n, kind, evk, d, 1'b0);
    end
  endtask

  task automatic test_reset_mid_emit();
    run_frame("reset_mid_emit", 5'd16, 2, R + F + 100, 1000, 1'b0);
    @(negedge clk);
    checks++;
    if (dut_vec() !== 16'h0000) begin errors++; $display("FAIL reset_mid_emit_release: actual=%h required=0000", dut_vec()); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; n_slots_req = 5'd0; abort = 1'b0; il_out_en = 1'b0;
    test_reset();
    run_frame("single_n2", 5'd2, 0, 0, 3, 1'b0);
    test_cfg_err();
    test_timeout();
    test_abort();
    test_abort_idle();
    test_back_to_back();
    test_random();
    test_reset_mid_emit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
